// File: rtl/id_ex_operand_stage.sv
// ID-stage operand resolution with EX/MEM/WB forwarding, load-use bubble insertion,
// the ID/EX pipeline register and a saturating stall-cycle counter.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_dst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic [DW-1:0] id_rf_data1,
    input  logic [DW-1:0] id_rf_data2,
    input  logic          fwd_ex_regwrite,
    input  logic          fwd_ex_memread,
    input  logic [AW-1:0] fwd_ex_dst,
    input  logic [DW-1:0] fwd_ex_result,
    input  logic          fwd_mem_regwrite,
    input  logic [AW-1:0] fwd_mem_dst,
    input  logic [DW-1:0] fwd_mem_result,
    input  logic          fwd_wb_regwrite,
    input  logic [AW-1:0] fwd_wb_dst,
    input  logic [DW-1:0] fwd_wb_data,
    input  logic          flush,
    input  logic          ex_hold,
    output logic          stall,
    output logic          idex_valid,
    output logic          idex_regwrite,
    output logic          idex_memread,
    output logic [AW-1:0] idex_dst,
    output logic [DW-1:0] idex_opa,
    output logic [DW-1:0] idex_opb,
    output logic [CW-1:0] stall_cnt
);

    logic          ex_fwd_ok;
    logic          mem_fwd_ok;
    logic          wb_fwd_ok;
    logic          load_use;
    logic [DW-1:0] opa_res;
    logic [DW-1:0] opb_res;

    logic          idex_valid_d,    idex_valid_q;
    logic          idex_regwrite_d, idex_regwrite_q;
    logic          idex_memread_d,  idex_memread_q;
    logic [AW-1:0] idex_dst_d,      idex_dst_q;
    logic [DW-1:0] idex_opa_d,      idex_opa_q;
    logic [DW-1:0] idex_opb_d,      idex_opb_q;
    logic [CW-1:0] stall_cnt_d,     stall_cnt_q;

    // A load in EX has no data yet, so it can only stall, never forward.
    always_comb begin
        ex_fwd_ok  = fwd_ex_regwrite && !fwd_ex_memread && (fwd_ex_dst != '0);
        mem_fwd_ok = fwd_mem_regwrite && (fwd_mem_dst != '0);
        wb_fwd_ok  = fwd_wb_regwrite && (fwd_wb_dst != '0);

        opa_res = id_rf_data1;
        if (id_rs == '0)
            opa_res = '0;
        else if (ex_fwd_ok && (fwd_ex_dst == id_rs))
            opa_res = fwd_ex_result;
        else if (mem_fwd_ok && (fwd_mem_dst == id_rs))
            opa_res = fwd_mem_result;
        else if (wb_fwd_ok && (fwd_wb_dst == id_rs))
            opa_res = fwd_wb_data;

        opb_res = id_rf_data2;
        if (id_rt == '0)
            opb_res = '0;
        else if (ex_fwd_ok && (fwd_ex_dst == id_rt))
            opb_res = fwd_ex_result;
        else if (mem_fwd_ok && (fwd_mem_dst == id_rt))
            opb_res = fwd_mem_result;
        else if (wb_fwd_ok && (fwd_wb_dst == id_rt))
            opb_res = fwd_wb_data;
    end

    always_comb begin
        load_use = id_valid && fwd_ex_regwrite && fwd_ex_memread && (fwd_ex_dst != '0) &&
                   ((id_use_rs && (fwd_ex_dst == id_rs)) || (id_use_rt && (fwd_ex_dst == id_rt)));
        stall    = ex_hold || (load_use && !flush);
    end

    // Hold beats flush: the upstream stages keep the flush request alive until EX frees up.
    always_comb begin
        idex_valid_d    = idex_valid_q;
        idex_regwrite_d = idex_regwrite_q;
        idex_memread_d  = idex_memread_q;
        idex_dst_d      = idex_dst_q;
        idex_opa_d      = idex_opa_q;
        idex_opb_d      = idex_opb_q;
        if (ex_hold) begin
            idex_valid_d = idex_valid_q;
        end else if (flush || load_use) begin
            idex_valid_d    = 1'b0;
            idex_regwrite_d = 1'b0;
            idex_memread_d  = 1'b0;
            idex_dst_d      = '0;
            idex_opa_d      = '0;
            idex_opb_d      = '0;
        end else begin
            idex_valid_d    = id_valid;
            idex_regwrite_d = id_regwrite && id_valid;
            idex_memread_d  = id_memread && id_valid;
            idex_dst_d      = id_dst;
            idex_opa_d      = opa_res;
            idex_opb_d      = opb_res;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CW{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_valid_q    <= 1'b0;
            idex_regwrite_q <= 1'b0;
            idex_memread_q  <= 1'b0;
            idex_dst_q      <= '0;
            idex_opa_q      <= '0;
            idex_opb_q      <= '0;
            stall_cnt_q     <= '0;
        end else begin
            idex_valid_q    <= idex_valid_d;
            idex_regwrite_q <= idex_regwrite_d;
            idex_memread_q  <= idex_memread_d;
            idex_dst_q      <= idex_dst_d;
            idex_opa_q      <= idex_opa_d;
            idex_opb_q      <= idex_opb_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign idex_valid    = idex_valid_q;
    assign idex_regwrite = idex_regwrite_q;
    assign idex_memread  = idex_memread_q;
    assign idex_dst      = idex_dst_q;
    assign idex_opa      = idex_opa_q;
    assign idex_opb      = idex_opb_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; a second instance with a 4-bit counter
// shares all inputs so counter saturation can be reached quickly.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic [31:0] id_rf_data1, id_rf_data2;
    logic        fwd_ex_regwrite, fwd_ex_memread;
    logic [4:0]  fwd_ex_dst, fwd_mem_dst, fwd_wb_dst;
    logic [31:0] fwd_ex_result, fwd_mem_result, fwd_wb_data;
    logic        fwd_mem_regwrite, fwd_wb_regwrite;
    logic        flush, ex_hold;

    logic        stall, idex_valid, idex_regwrite, idex_memread;
    logic [4:0]  idex_dst;
    logic [31:0] idex_opa, idex_opb;
    logic [15:0] stall_cnt;

    logic        s_stall, s_valid, s_regwrite, s_memread;
    logic [4:0]  s_dst;
    logic [31:0] s_opa, s_opb;
    logic [3:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_rf_data1(id_rf_data1), .id_rf_data2(id_rf_data2),
        .fwd_ex_regwrite(fwd_ex_regwrite), .fwd_ex_memread(fwd_ex_memread),
        .fwd_ex_dst(fwd_ex_dst), .fwd_ex_result(fwd_ex_result),
        .fwd_mem_regwrite(fwd_mem_regwrite), .fwd_mem_dst(fwd_mem_dst),
        .fwd_mem_result(fwd_mem_result), .fwd_wb_regwrite(fwd_wb_regwrite),
        .fwd_wb_dst(fwd_wb_dst), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .ex_hold(ex_hold), .stall(stall), .idex_valid(idex_valid),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_dst(idex_dst),
        .idex_opa(idex_opa), .idex_opb(idex_opb), .stall_cnt(stall_cnt)
    );

    id_ex_operand_stage #(.DW(32), .AW(5), .CW(4)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_rf_data1(id_rf_data1), .id_rf_data2(id_rf_data2),
        .fwd_ex_regwrite(fwd_ex_regwrite), .fwd_ex_memread(fwd_ex_memread),
        .fwd_ex_dst(fwd_ex_dst), .fwd_ex_result(fwd_ex_result),
        .fwd_mem_regwrite(fwd_mem_regwrite), .fwd_mem_dst(fwd_mem_dst),
        .fwd_mem_result(fwd_mem_result), .fwd_wb_regwrite(fwd_wb_regwrite),
        .fwd_wb_dst(fwd_wb_dst), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .ex_hold(ex_hold), .stall(s_stall), .idex_valid(s_valid),
        .idex_regwrite(s_regwrite), .idex_memread(s_memread), .idex_dst(s_dst),
        .idex_opa(s_opa), .idex_opb(s_opb), .stall_cnt(s_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        reset = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
        id_rf_data1 = '0; id_rf_data2 = '0;
        fwd_ex_regwrite = 1'b0; fwd_ex_memread = 1'b0; fwd_ex_dst = '0; fwd_ex_result = '0;
        fwd_mem_regwrite = 1'b0; fwd_mem_dst = '0; fwd_mem_result = '0;
        fwd_wb_regwrite = 1'b0; fwd_wb_dst = '0; fwd_wb_data = '0;
        flush = 1'b0; ex_hold = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus();
        #1;
        // Reset with random inputs
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
            id_dst = 5'($urandom); id_regwrite = 1'($urandom); id_memread = 1'($urandom);
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_rf_data1 = $urandom; id_rf_data2 = $urandom;
            fwd_ex_regwrite = 1'($urandom); fwd_ex_memread = 1'($urandom);
            fwd_ex_dst = 5'($urandom); fwd_ex_result = $urandom;
            fwd_mem_regwrite = 1'($urandom); fwd_mem_dst = 5'($urandom);
            fwd_mem_result = $urandom; flush = 1'($urandom); ex_hold = 1'($urandom);
            tick();
        end
        checkOutput("rst_valid", {31'd0, idex_valid}, 32'd0);
        checkOutput("rst_regwrite", {31'd0, idex_regwrite}, 32'd0);
        checkOutput("rst_memread", {31'd0, idex_memread}, 32'd0);
        checkOutput("rst_dst", {27'd0, idex_dst}, 32'd0);
        checkOutput("rst_opa", idex_opa, 32'd0);
        checkOutput("rst_opb", idex_opb, 32'd0);
        checkOutput("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        checkOutput("rst_sat_cnt", {28'd0, s_cnt}, 32'd0);

        // First instruction after reset, no forwarding
        applyStimulus();
        id_valid = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1; id_rf_data1 = 32'h11;
        id_dst = 5'd4; id_regwrite = 1'b1;
        tick();
        checkOutput("first_opa", idex_opa, 32'h11);
        checkOutput("first_valid", {31'd0, idex_valid}, 32'd1);
        checkOutput("first_regwrite", {31'd0, idex_regwrite}, 32'd1);
        checkOutput("first_dst", {27'd0, idex_dst}, 32'd4);

        // Forward priority EX > MEM > WB > RF
        id_rs = 5'd5; id_rf_data1 = 32'h5555;
        fwd_ex_regwrite = 1'b1; fwd_ex_dst = 5'd5; fwd_ex_result = 32'hAAAA;
        fwd_mem_regwrite = 1'b1; fwd_mem_dst = 5'd5; fwd_mem_result = 32'hBBBB;
        fwd_wb_regwrite = 1'b1; fwd_wb_dst = 5'd5; fwd_wb_data = 32'hCCCC;
        tick();
        checkOutput("fwd_ex", idex_opa, 32'hAAAA);
        fwd_ex_regwrite = 1'b0;
        tick();
        checkOutput("fwd_mem", idex_opa, 32'hBBBB);
        fwd_mem_regwrite = 1'b0;
        tick();
        checkOutput("fwd_wb", idex_opa, 32'hCCCC);
        fwd_wb_regwrite = 1'b0;
        tick();
        checkOutput("fwd_rf", idex_opa, 32'h5555);
        id_rs = 5'd0;
        fwd_ex_regwrite = 1'b1; fwd_ex_dst = 5'd0;
        fwd_mem_regwrite = 1'b1; fwd_mem_dst = 5'd0;
        fwd_wb_regwrite = 1'b1; fwd_wb_dst = 5'd0;
        tick();
        checkOutput("fwd_r0", idex_opa, 32'd0);
        // rt path: MEM beats WB, EX points elsewhere
        applyStimulus();
        id_valid = 1'b1; id_rt = 5'd7; id_use_rt = 1'b1; id_rf_data2 = 32'h7777;
        fwd_ex_regwrite = 1'b1; fwd_ex_dst = 5'd6; fwd_ex_result = 32'h6666;
        fwd_mem_regwrite = 1'b1; fwd_mem_dst = 5'd7; fwd_mem_result = 32'h1717;
        fwd_wb_regwrite = 1'b1; fwd_wb_dst = 5'd7; fwd_wb_data = 32'h2727;
        tick();
        checkOutput("fwd_rt_mem", idex_opb, 32'h1717);

        // Load-use: one bubble, then MEM forward
        applyStimulus();
        id_valid = 1'b1; id_rt = 5'd8; id_use_rt = 1'b1; id_rf_data2 = 32'hDEAD;
        id_dst = 5'd9; id_regwrite = 1'b1;
        fwd_ex_regwrite = 1'b1; fwd_ex_memread = 1'b1; fwd_ex_dst = 5'd8;
        fwd_ex_result = 32'hFFFF;
        #1;
        checkOutput("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("lu_bubble_valid", {31'd0, idex_valid}, 32'd0);
        checkOutput("lu_bubble_regwrite", {31'd0, idex_regwrite}, 32'd0);
        checkOutput("lu_bubble_opb", idex_opb, 32'd0);
        checkOutput("lu_cnt_after_bubble", {16'd0, stall_cnt}, 32'd1);
        fwd_ex_regwrite = 1'b0; fwd_ex_memread = 1'b0; fwd_ex_dst = '0;
        fwd_mem_regwrite = 1'b1; fwd_mem_dst = 5'd8; fwd_mem_result = 32'h1234;
        #1;
        checkOutput("lu_release_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("lu_opb_mem", idex_opb, 32'h1234);
        checkOutput("lu_valid", {31'd0, idex_valid}, 32'd1);
        checkOutput("lu_cnt", {16'd0, stall_cnt}, 32'd1);

        // Use-flag filter
        applyStimulus();
        id_valid = 1'b1; id_rt = 5'd8; id_use_rt = 1'b0; id_rs = 5'd2; id_use_rs = 1'b1;
        id_rf_data2 = 32'hDEAD;
        fwd_ex_regwrite = 1'b1; fwd_ex_memread = 1'b1; fwd_ex_dst = 5'd8;
        #1;
        checkOutput("filter_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("filter_valid", {31'd0, idex_valid}, 32'd1);
        checkOutput("filter_opb", idex_opb, 32'hDEAD);

        // Flush together with load-use: no stall, bubble loaded
        id_use_rt = 1'b1; id_dst = 5'd3; id_regwrite = 1'b1; flush = 1'b1;
        #1;
        checkOutput("flush_lu_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("flush_valid", {31'd0, idex_valid}, 32'd0);
        checkOutput("flush_dst", {27'd0, idex_dst}, 32'd0);

        // Hold beats flush
        applyStimulus();
        id_valid = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1; id_rf_data1 = 32'h77;
        id_dst = 5'd9; id_regwrite = 1'b1; id_memread = 1'b1;
        tick();
        checkOutput("pre_hold_valid", {31'd0, idex_valid}, 32'd1);
        checkOutput("pre_hold_memread", {31'd0, idex_memread}, 32'd1);
        id_dst = 5'd10; id_rf_data1 = 32'h99; ex_hold = 1'b1; flush = 1'b1;
        #1;
        checkOutput("hold_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("hold_dst", {27'd0, idex_dst}, 32'd9);
        checkOutput("hold_opa", idex_opa, 32'h77);
        checkOutput("hold_valid", {31'd0, idex_valid}, 32'd1);
        checkOutput("hold_cnt", {16'd0, stall_cnt}, 32'd2);

        // Saturation of the 4-bit counter
        flush = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checkOutput($sformatf("sat_cnt_%0d", i), {28'd0, s_cnt},
                        (2 + i > 15) ? 32'd15 : 32'(2 + i));
        end
        checkOutput("wide_cnt", {16'd0, stall_cnt}, 32'd22);
        ex_hold = 1'b0;
        tick();
        checkOutput("sat_stay", {28'd0, s_cnt}, 32'd15);
        checkOutput("wide_stay", {16'd0, stall_cnt}, 32'd22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
Operand-fetch back half of the decode stage in the 5-stage pipelined CPU. It takes the two raw register-file read values and resolves RAW hazards by forwarding from EX, MEM and WB. It detects load-use hazards and raises a stall with a bubble. It registers the resolved operands and control bits into the ID/EX pipeline register, and keeps a saturating stall-cycle performance counter.

Parameters:
DW, 32, datapath width
AW, 5, register address width (32 architectural registers, register 0 hard-wired to zero)
CW, 16, stall performance counter width

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs, id_rt  in  AW  source register addresses, also driven to the register file read ports
id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
id_dst  in  AW  destination register of the ID instruction
id_regwrite, id_memread  in  1  ID instruction writes a register / is a load
id_rf_data1, id_rf_data2  in  DW  register-file read data for rs / rt
fwd_ex_regwrite, fwd_ex_memread  in  1  control of the instruction currently in EX
fwd_ex_dst  in  AW  EX destination; fwd_ex_result  in  DW  EX ALU result (combinational)
fwd_mem_regwrite  in  1; fwd_mem_dst  in  AW; fwd_mem_result  in  DW  MEM-stage writeback value
fwd_wb_regwrite  in  1; fwd_wb_dst  in  AW; fwd_wb_data  in  DW  same values as the register-file write port
flush  in  1  kill the ID instruction (taken branch/jump)
ex_hold  in  1  EX busy; ID/EX must not advance
stall  out  1  freeze PC and IF/ID (combinational)
idex_valid, idex_regwrite, idex_memread  out  1  registered control
idex_dst  out  AW; idex_opa, idex_opb  out  DW  registered resolved operands
stall_cnt  out  CW  cycles with stall=1, saturating

Behaviour:
- Reset (reset=1 at a clk edge): all idex_* outputs and stall_cnt go to 0. stall is combinational and still evaluates during reset.
- Operand resolution (combinational, per source, rs shown; rt is identical):
  - address 0 -> 0.
  - else if fwd_ex_regwrite && !fwd_ex_memread && fwd_ex_dst==rs -> fwd_ex_result.
  - else if fwd_mem_regwrite && fwd_mem_dst==rs -> fwd_mem_result.
  - else if fwd_wb_regwrite && fwd_wb_dst==rs -> fwd_wb_data. This bypass is required because the register file writes on the same edge, so its read is stale.
  - else id_rf_data1.
  - Priority is youngest first: EX > MEM > WB > register file. A forward source whose dst is 0 never matches.
- Load-use: lu = id_valid && fwd_ex_regwrite && fwd_ex_memread && fwd_ex_dst!=0 && ((id_use_rs && fwd_ex_dst==id_rs) || (id_use_rt && fwd_ex_dst==id_rt)).
- stall = ex_hold || (lu && !flush).
- ID/EX register update, priority per edge:
  - reset: clear.
  - ex_hold: hold all idex_* unchanged. flush is ignored here; upstream retains the flush.
  - flush: load a bubble (valid/regwrite/memread=0, dst=0, operands=0).
  - lu: load a bubble, identical to the flush case.
  - otherwise: load the resolved operands; idex_valid=id_valid, idex_regwrite=id_regwrite&&id_valid, idex_memread=id_memread&&id_valid, idex_dst=id_dst.
- Latency: one cycle from ID inputs to idex_* outputs. A load-use costs exactly one bubble. On the next cycle the load sits in MEM and the value forwards from fwd_mem_result.
- stall_cnt: increments on every edge with stall=1 and reset=0. It saturates at 2^CW-1 and never wraps.
- A bubble never asserts regwrite or memread, so it cannot create a false forward or false load-use downstream.

Test Plan:
1. Reset: drive random inputs with reset=1 for 2 cycles -> all idex_*=0 and stall_cnt=0. Release reset, issue rs=3 with rf_data1=0x11 and no forwards -> idex_opa=0x11 one cycle later.
2. Forward priority: rs=5 with EX result=0xAAAA, MEM=0xBBBB and WB=0xCCCC all targeting r5 -> opa=0xAAAA. Drop EX -> 0xBBBB. Drop MEM -> 0xCCCC. Drop WB -> rf_data1. Set rs=0 with all three forwards targeting r0 -> opa=0.
3. Load-use: EX holds a load to r8 and ID uses rt=8 -> stall=1 and a bubble (idex_valid=0) is captured. Next cycle the load is in MEM with fwd_mem_result=0x1234 -> stall=0, idex_opb=0x1234, stall_cnt=1.
4. Use-flag filter: load to r8 in EX, ID has rt=8 but id_use_rt=0 -> stall=0 and no bubble.
5. Flush vs load-use: lu and flush both asserted -> stall=0 and a bubble is loaded. ex_hold=1 together with flush -> idex_* unchanged and stall=1.
6. Saturation: set CW=4 and hold ex_hold=1 for 20 cycles -> stall_cnt climbs to 15 and stays at 15.
